ysyx_22041752_mem_arbiter: RTL and testbench

- Shares one unified memory port between the instruction-fetch requester (read-only) and the data requester (read/write with byte strobes).
- Sits in top, between the IFU inst interface / EXU-MEU data interface and a single external memory port.
- Uses a grant-latching FSM with one outstanding transaction.
- Arbitration gives data priority, with an anti-starvation streak counter for fetch.

---
 rtl/ysyx_22041752_mem_arbiter_pkg.sv | 17 +
 rtl/ysyx_22041752_arb_prio.sv | 41 ++++
 rtl/ysyx_22041752_mem_arbiter.sv | 97 +++++++++
 tb/tb_ysyx_22041752_mem_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22041752_mem_arbiter_pkg.sv
// Shared types and helpers for the unified memory port arbiter.
package ysyx_22041752_mem_arbiter_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE   = 3'd0,
        ARB_REQ_I  = 3'd1,
        ARB_REQ_D  = 3'd2,
        ARB_WAIT_I = 3'd3,
        ARB_WAIT_D = 3'd4
    } arb_state_t;

    // Streak counter must be able to hold the value MAX_STREAK itself.
    function automatic int unsigned arb_streak_wd(input int unsigned max_streak);
        return $clog2(max_streak + 1);
    endfunction

endpackage

// File: rtl/ysyx_22041752_arb_prio.sv
// Data-priority arbiter with an anti-starvation streak counter for fetch.
module ysyx_22041752_arb_prio
    import ysyx_22041752_mem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_STREAK = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inst_req,
    input  logic data_req,
    input  logic upd_en,
    output logic grant_data
);

    localparam int unsigned STREAK_WD = arb_streak_wd(MAX_STREAK);
    localparam logic [STREAK_WD-1:0] STREAK_MAX = STREAK_WD'(MAX_STREAK);
    localparam logic [STREAK_WD-1:0] STREAK_ONE = STREAK_WD'(1);

    logic [STREAK_WD-1:0] streak;
    logic                 contested;
    logic                 forced_inst;

    always_comb begin
        contested   = inst_req & data_req;
        forced_inst = contested & (streak == STREAK_MAX);
        grant_data  = data_req & ~forced_inst;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            streak <= '0;
        end else if (upd_en) begin
            // Only contested data wins extend the streak; anything else clears it.
            if (contested & grant_data)
                streak <= (streak == STREAK_MAX) ? streak : streak + STREAK_ONE;
            else
                streak <= '0;
        end
    end

endmodule

// File: rtl/ysyx_22041752_mem_arbiter.sv
// Shares one memory port between instruction fetch and data accesses,
// one outstanding transaction at a time.
module ysyx_22041752_mem_arbiter
    import ysyx_22041752_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WD    = 64,
    parameter int unsigned DATA_WD    = 64,
    parameter int unsigned WEN_WD     = 8,
    parameter int unsigned MAX_STREAK = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inst_req,
    input  logic [ADDR_WD-1:0] inst_addr,
    output logic               inst_addr_ok,
    output logic               inst_data_ok,
    output logic [DATA_WD-1:0] inst_rdata,
    input  logic               data_req,
    input  logic [WEN_WD-1:0]  data_wen,
    input  logic [ADDR_WD-1:0] data_addr,
    input  logic [DATA_WD-1:0] data_wdata,
    output logic               data_addr_ok,
    output logic               data_data_ok,
    output logic [DATA_WD-1:0] data_rdata,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [WEN_WD-1:0]  mem_wen,
    output logic [ADDR_WD-1:0] mem_addr,
    output logic [DATA_WD-1:0] mem_wdata,
    input  logic               mem_resp_valid,
    input  logic [DATA_WD-1:0] mem_rdata,
    output logic               arb_busy
);

    arb_state_t         state, state_nxt;
    logic               accept;
    logic               grant_data;
    logic [WEN_WD-1:0]  wen_q;
    logic [ADDR_WD-1:0] addr_q;
    logic [DATA_WD-1:0] wdata_q;

    assign accept = (state == ARB_IDLE) & (inst_req | data_req);

    ysyx_22041752_arb_prio #(
        .MAX_STREAK(MAX_STREAK)
    ) u_prio (
        .clk       (clk),
        .reset     (reset),
        .inst_req  (inst_req),
        .data_req  (data_req),
        .upd_en    (accept),
        .grant_data(grant_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ARB_IDLE;
            wen_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                wen_q   <= grant_data ? data_wen   : '0;
                addr_q  <= grant_data ? data_addr  : inst_addr;
                wdata_q <= grant_data ? data_wdata : '0;
            end
        end
    end

    // The REQ_I/REQ_D and WAIT_I/WAIT_D states carry the latched grant.
    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE:   if (inst_req | data_req) state_nxt = grant_data ? ARB_REQ_D : ARB_REQ_I;
            ARB_REQ_I:  if (mem_req_ready)       state_nxt = ARB_WAIT_I;
            ARB_REQ_D:  if (mem_req_ready)       state_nxt = ARB_WAIT_D;
            ARB_WAIT_I: if (mem_resp_valid)      state_nxt = ARB_IDLE;
            ARB_WAIT_D: if (mem_resp_valid)      state_nxt = ARB_IDLE;
            default:                             state_nxt = ARB_IDLE;
        endcase
    end

    assign mem_req_valid = (state == ARB_REQ_I) | (state == ARB_REQ_D);
    assign mem_wen       = wen_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign arb_busy      = (state != ARB_IDLE);

    assign inst_addr_ok  = (state == ARB_REQ_I) & mem_req_ready;
    assign data_addr_ok  = (state == ARB_REQ_D) & mem_req_ready;
    assign inst_data_ok  = (state == ARB_WAIT_I) & mem_resp_valid;
    assign data_data_ok  = (state == ARB_WAIT_D) & mem_resp_valid;
    assign inst_rdata    = inst_data_ok ? mem_rdata : '0;
    assign data_rdata    = data_data_ok ? mem_rdata : '0;

endmodule

// File: tb/tb_ysyx_22041752_mem_arbiter.sv
// Directed bench for the memory arbiter with a transaction-level reference model.
module tb_ysyx_22041752_mem_arbiter;

    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;
    localparam int unsigned WW = 8;
    localparam int          MS = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          inst_req;
    logic [AW-1:0] inst_addr;
    logic          inst_addr_ok, inst_data_ok;
    logic [DW-1:0] inst_rdata;
    logic          data_req;
    logic [WW-1:0] data_wen;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata;
    logic          data_addr_ok, data_data_ok;
    logic [DW-1:0] data_rdata;
    logic          mem_req_valid, mem_req_ready;
    logic [WW-1:0] mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_resp_valid;
    logic [DW-1:0] mem_rdata;
    logic          arb_busy;

    always #5 clk = ~clk;

    ysyx_22041752_mem_arbiter #(
        .ADDR_WD(AW), .DATA_WD(DW), .WEN_WD(WW), .MAX_STREAK(MS)
    ) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .arb_busy(arb_busy)
    );

    int    checks = 0;
    int    passes = 0;
    string glog   = "";

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: the one transaction in flight (owner 0=none 1=inst 2=data),
    // whether memory has accepted it, and the payload the memory port must show.
    int          m_who    = 0;
    logic        m_acc    = 1'b0;
    logic [63:0] m_addr   = '0;
    logic [63:0] m_wdata  = '0;
    logic [7:0]  m_wen    = '0;
    int          m_streak = 0;
    logic        m_valid  = 1'b0;
    logic        m_gd;

    assign m_gd = data_req && !(inst_req && (m_streak >= MS));

    always @(posedge clk) begin
        if (reset) begin
            m_who <= 0; m_acc <= 1'b0; m_addr <= '0; m_wdata <= '0; m_wen <= '0;
            m_streak <= 0; m_valid <= 1'b1;
        end else if (m_valid) begin
            if (m_who == 0) begin
                if (inst_req || data_req) begin
                    m_who   <= m_gd ? 2 : 1;
                    m_acc   <= 1'b0;
                    m_addr  <= m_gd ? data_addr  : inst_addr;
                    m_wen   <= m_gd ? data_wen   : '0;
                    m_wdata <= m_gd ? data_wdata : '0;
                    m_streak <= (inst_req && data_req && m_gd) ?
                                ((m_streak + 1 > MS) ? MS : m_streak + 1) : 0;
                end
            end else if (!m_acc) begin
                if (mem_req_ready) m_acc <= 1'b1;
            end else if (mem_resp_valid) begin
                m_who <= 0;
                m_acc <= 1'b0;
            end
        end
    end

    logic        e_req, e_iaok, e_daok, e_idok, e_ddok;
    logic [63:0] e_irdata, e_drdata;
    assign e_req    = (m_who != 0) && !m_acc;
    assign e_iaok   = (m_who == 1) && !m_acc && mem_req_ready;
    assign e_daok   = (m_who == 2) && !m_acc && mem_req_ready;
    assign e_idok   = (m_who == 1) && m_acc && mem_resp_valid;
    assign e_ddok   = (m_who == 2) && m_acc && mem_resp_valid;
    assign e_irdata = e_idok ? mem_rdata : '0;
    assign e_drdata = e_ddok ? mem_rdata : '0;

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            chk1 ("mem_req_valid", mem_req_valid, e_req);
            chk1 ("inst_addr_ok",  inst_addr_ok,  e_iaok);
            chk1 ("data_addr_ok",  data_addr_ok,  e_daok);
            chk1 ("inst_data_ok",  inst_data_ok,  e_idok);
            chk1 ("data_data_ok",  data_data_ok,  e_ddok);
            chk64("inst_rdata",    inst_rdata,    e_irdata);
            chk64("data_rdata",    data_rdata,    e_drdata);
            chk64("mem_addr",      mem_addr,      m_addr);
            chk64("mem_wdata",     mem_wdata,     m_wdata);
            chk64("mem_wen",       64'(mem_wen),  64'(m_wen));
            chk1 ("arb_busy",      arb_busy,      m_who != 0);
            if (inst_addr_ok === 1'b1) glog = {glog, "I"};
            if (data_addr_ok === 1'b1) glog = {glog, "D"};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; inst_req = 1'b0; inst_addr = '0; data_req = 1'b0; data_wen = '0;
        data_addr = '0; data_wdata = '0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
        repeat (2) tick();
        reset = 1'b0;
        @(negedge clk);
        chk1 ("lit_reset_valid", mem_req_valid, 1'b0);
        chk1 ("lit_reset_busy",  arb_busy,      1'b0);
        chk64("lit_reset_addr",  mem_addr,      64'h0);

        // Lone fetch
        tick(); inst_req = 1'b1; inst_addr = 64'h8000_0000; mem_req_ready = 1'b1;
        tick(); @(negedge clk);
        chk1 ("lit_fetch_aok",  inst_addr_ok, 1'b1);
        chk1 ("lit_fetch_daok", data_addr_ok, 1'b0);
        chk64("lit_fetch_addr", mem_addr,     64'h8000_0000);
        tick(); inst_req = 1'b0; mem_req_ready = 1'b0;
        tick(); mem_resp_valid = 1'b1; mem_rdata = 64'h13;
        @(negedge clk);
        chk1 ("lit_fetch_dok",   inst_data_ok, 1'b1);
        chk64("lit_fetch_rdata", inst_rdata,   64'h13);
        chk1 ("lit_fetch_ddok",  data_data_ok, 1'b0);
        chk64("lit_fetch_drd",   data_rdata,   64'h0);
        tick(); mem_resp_valid = 1'b0; mem_rdata = '0;

        // Contention: data first, then fetch
        tick(); inst_req = 1'b1; inst_addr = 64'h8000_0004;
        data_req = 1'b1; data_wen = 8'hFF; data_addr = 64'h8000_1000; data_wdata = 64'hDEAD_BEEF;
        mem_req_ready = 1'b1;
        tick(); @(negedge clk);
        chk1 ("lit_cont_daok",  data_addr_ok, 1'b1);
        chk1 ("lit_cont_iaok",  inst_addr_ok, 1'b0);
        chk64("lit_cont_wen",   64'(mem_wen), 64'hFF);
        chk64("lit_cont_wdata", mem_wdata,    64'hDEAD_BEEF);
        tick(); data_req = 1'b0; mem_req_ready = 1'b0;
        tick(); mem_resp_valid = 1'b1; mem_rdata = 64'h55;
        @(negedge clk);
        chk1 ("lit_cont_ddok", data_data_ok, 1'b1);
        chk1 ("lit_cont_idok", inst_data_ok, 1'b0);
        tick(); mem_resp_valid = 1'b0; mem_req_ready = 1'b1;
        tick(); @(negedge clk);
        chk1 ("lit_cont_iaok2", inst_addr_ok, 1'b1);
        chk64("lit_cont_iaddr", mem_addr,     64'h8000_0004);
        tick(); inst_req = 1'b0; mem_req_ready = 1'b0;
        tick(); mem_resp_valid = 1'b1; mem_rdata = 64'h77;
        tick(); mem_resp_valid = 1'b0;
        chk64("lit_model_streak_cont", 64'(m_streak), 64'h0);

        // Starvation guard: both requesters held continuously
        tick(); glog = ""; inst_req = 1'b1; data_req = 1'b1; data_wen = '0;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b1;
        begin
            int n;
            n = 0;
            while (glog.len() < 10 && n < 100) begin tick(); n++; end
            chk1("lit_starve_bound", n < 100, 1'b1);
        end
        inst_req = 1'b0; data_req = 1'b0;
        checks++;
        if (glog == "DDDDIDDDDI") passes++;
        else $display("FAIL grant_order: got %s expected DDDDIDDDDI", glog);
        chk64("lit_model_streak_guard", 64'(m_streak), 64'h0);
        tick(); tick(); mem_req_ready = 1'b0; mem_resp_valid = 1'b0;

        // Backpressure
        tick(); data_req = 1'b1; data_wen = 8'h0F; data_addr = 64'h8000_2000; data_wdata = 64'h1234;
        tick(); data_req = 1'b0; inst_req = 1'b1; inst_addr = 64'h8000_3000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk64("lit_bp_addr", mem_addr,     64'h8000_2000);
            chk64("lit_bp_wen",  64'(mem_wen), 64'h0F);
            chk1 ("lit_bp_daok", data_addr_ok, 1'b0);
            chk1 ("lit_bp_iaok", inst_addr_ok, 1'b0);
            tick();
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        chk1 ("lit_bp_daok_rdy", data_addr_ok, 1'b1);
        chk64("lit_bp_addr_rdy", mem_addr,     64'h8000_2000);
        tick(); mem_req_ready = 1'b0;
        tick(); mem_resp_valid = 1'b1; mem_rdata = 64'h99;
        @(negedge clk);
        chk1("lit_bp_ddok", data_data_ok, 1'b1);
        tick(); mem_resp_valid = 1'b0;
        tick(); mem_req_ready = 1'b1;
        @(negedge clk);
        chk1 ("lit_bp_iaok2", inst_addr_ok, 1'b1);
        chk64("lit_bp_iaddr", mem_addr,     64'h8000_3000);
        tick(); inst_req = 1'b0; mem_req_ready = 1'b0;
        tick(); mem_resp_valid = 1'b1;
        tick(); mem_resp_valid = 1'b0;

        // Reset while waiting on a data response
        tick(); data_req = 1'b1; data_wen = '0; data_addr = 64'h8000_4000; mem_req_ready = 1'b1;
        tick(); data_req = 1'b0;
        tick(); mem_req_ready = 1'b0; reset = 1'b1;
        tick(); reset = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 64'hAA;
        @(negedge clk);
        chk1 ("lit_rst_ddok",  data_data_ok,  1'b0);
        chk1 ("lit_rst_busy",  arb_busy,      1'b0);
        chk1 ("lit_rst_valid", mem_req_valid, 1'b0);
        chk64("lit_rst_addr",  mem_addr,      64'h0);
        chk64("lit_rst_drd",   data_rdata,    64'h0);
        chk64("lit_model_streak_rst", 64'(m_streak), 64'h0);

        // Stray responses while idle
        tick();
        @(negedge clk);
        chk1("lit_stray_idok", inst_data_ok, 1'b0);
        chk1("lit_stray_ddok", data_data_ok, 1'b0);
        chk1("lit_stray_busy", arb_busy,     1'b0);
        tick(); mem_resp_valid = 1'b0; mem_rdata = '0;
        repeat (2) tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
